// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared types for the seven-bag piece sequencer: piece
//                encoding, the full-bag constant, the generator state
//                encoding and a bag-update helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I    = 3'd0,
        PIECE_O    = 3'd1,
        PIECE_T    = 3'd2,
        PIECE_S    = 3'd3,
        PIECE_Z    = 3'd4,
        PIECE_J    = 3'd5,
        PIECE_L    = 3'd6,
        PIECE_NONE = 3'd7
    } piece_t;

    // One bit per piece; 1 = piece still available in the current bag.
    localparam logic [6:0] BAG_FULL = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PICK  = 2'd2
    } gen_state_t;

    // One-hot bag mask for a candidate; candidate 7 maps to no bit at all.
    function automatic logic [6:0] piece_mask(input logic [2:0] idx);
        return 7'd1 << idx;
    endfunction

    // Remove a piece from the bag, refilling on the same edge when the
    // last remaining piece is taken.
    function automatic logic [6:0] bag_take(input logic [6:0] bag, input logic [2:0] idx);
        logic [6:0] left;
        left = bag & ~piece_mask(idx);
        return (left == 7'd0) ? BAG_FULL : left;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_bag_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : piece_bag_sched_if
//  Description : Bundle between the sequencer, the LFSR source and the two
//                per-player game-logic blocks.
//                  rnd_bit     : random bit, consumed only while shifting
//                  restart     : synchronous game restart
//                  pop[1:0]    : per-player consume of the head piece
//                  piece_valid : per-player "unread piece available"
//                  piece_p0/p1 : per-player head piece (NONE when empty)
//                  queue_full  : slowest player's occupancy is at capacity
//                master = game side (drives rnd/restart/pop), slave = sequencer
//  Revision    : 1.0  initial release
// ============================================================================
interface piece_bag_sched_if;
    import tetris_pkg::*;

    logic       rnd_bit;
    logic       restart;
    logic [1:0] pop;
    logic [1:0] piece_valid;
    piece_t     piece_p0;
    piece_t     piece_p1;
    logic       queue_full;

    modport master (
        output rnd_bit, restart, pop,
        input  piece_valid, piece_p0, piece_p1, queue_full
    );

    modport slave (
        input  rnd_bit, restart, pop,
        output piece_valid, piece_p0, piece_p1, queue_full
    );

endinterface
`default_nettype wire

// File: rtl/bag_draw_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : bag_draw_fsm
//  Description : Seven-bag shuffler. Shifts three random bits into a
//                candidate, then accepts it if it names a piece still in the
//                bag, otherwise redraws (rejection sampling).
//  Ports       : clk, rst_l        clock, async active-low reset
//                rnd_bit           random bit, sampled in SHIFT only
//                restart           synchronous abort of draw and bag
//                full              buffer full (registered pointers)
//                full_after_wr     buffer would be full after this write,
//                                  accounting for same-edge pops
//                wr_en, wr_piece   write strobe and piece for the buffer
//  Revision    : 1.0  initial release
// ============================================================================
module bag_draw_fsm
    import tetris_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_l,
    input  wire logic   rnd_bit,
    input  wire logic   restart,
    input  wire logic   full,
    input  wire logic   full_after_wr,
    output logic        wr_en,
    output piece_t      wr_piece
);

    gen_state_t r_state;
    gen_state_t w_state_nxt;
    logic [2:0] r_cand;
    logic [2:0] w_cand_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [6:0] r_bag;
    logic [6:0] w_bag_nxt;
    logic       w_accept;

    // Candidate 7 has no bag bit, so the mask test also rejects it.
    assign w_accept = |(r_bag & piece_mask(r_cand));
    assign wr_piece = piece_t'(r_cand);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= IDLE;
            r_cand  <= 3'd0;
            r_cnt   <= 2'd0;
            r_bag   <= BAG_FULL;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bag   <= w_bag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_bag_nxt   = r_bag;
        wr_en       = 1'b0;

        case (r_state)
            IDLE: begin
                if (!full) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = 2'd0;
                end
            end
            SHIFT: begin
                w_cand_nxt = {r_cand[1:0], rnd_bit};
                w_cnt_nxt  = 2'(r_cnt + 2'd1);
                if (r_cnt == 2'd2) begin
                    w_state_nxt = PICK;
                end
            end
            PICK: begin
                w_cnt_nxt = 2'd0;
                if (w_accept) begin
                    wr_en       = 1'b1;
                    w_bag_nxt   = bag_take(r_bag, r_cand);
                    w_state_nxt = full_after_wr ? IDLE : SHIFT;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Restart overrides everything, including a write in PICK.
        if (restart) begin
            w_state_nxt = IDLE;
            w_cand_nxt  = 3'd0;
            w_cnt_nxt   = 2'd0;
            w_bag_nxt   = BAG_FULL;
            wr_en       = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piece_bag_sched.sv
`default_nettype none
// ============================================================================
//  Module      : piece_bag_sched
//  Description : Two-player seven-bag piece sequencer. One shared sequence
//                buffer written by the shuffler; each player reads it with
//                an independent pointer so both see the same sequence.
//  Ports       : clk, rst_l   clock, async active-low reset
//                bus (slave)  rnd_bit, restart, pop[1:0] in;
//                             piece_valid[1:0], piece_p0, piece_p1,
//                             queue_full out
//  Revision    : 1.0  initial release
// ============================================================================
module piece_bag_sched
    import tetris_pkg::*;
#(
    parameter int QDEPTH = 8
)
(
    input  wire logic           clk,
    input  wire logic           rst_l,
    piece_bag_sched_if.slave    bus
);

    localparam int PW = $clog2(QDEPTH) + 1;
    localparam logic [PW-1:0] c_depth = PW'(QDEPTH);
    localparam logic [PW-1:0] c_one   = PW'(1);

    piece_t                 r_buf [QDEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [1:0][PW-1:0]     r_rd_ptr;

    logic [PW-1:0]          w_wr_inc;
    logic [1:0][PW-1:0]     w_occ;
    logic [1:0][PW-1:0]     w_rd_post;
    logic [1:0][PW-1:0]     w_occ_post;
    logic [1:0]             w_valid;
    logic [1:0]             w_pop_ok;
    logic                   w_full;
    logic                   w_full_after_wr;
    logic                   w_wr_en;
    piece_t                 w_wr_piece;

    assign w_wr_inc = r_wr_ptr + c_one;

    for (genvar p = 0; p < 2; p++) begin : g_player
        // Mod-2^PW subtraction keeps occupancy right across pointer wrap.
        assign w_occ[p]      = r_wr_ptr - r_rd_ptr[p];
        assign w_valid[p]    = (w_occ[p] != '0);
        assign w_pop_ok[p]   = bus.pop[p] & w_valid[p];
        assign w_rd_post[p]  = r_rd_ptr[p] + (w_pop_ok[p] ? c_one : '0);
        assign w_occ_post[p] = w_wr_inc - w_rd_post[p];
    end

    // Occupancy never exceeds the depth, so "max == depth" reduces to
    // "either player at depth".
    assign w_full          = (w_occ[0] == c_depth) || (w_occ[1] == c_depth);
    assign w_full_after_wr = (w_occ_post[0] == c_depth) || (w_occ_post[1] == c_depth);

    bag_draw_fsm u_draw (
        .clk           (clk),
        .rst_l         (rst_l),
        .rnd_bit       (bus.rnd_bit),
        .restart       (bus.restart),
        .full          (w_full),
        .full_after_wr (w_full_after_wr),
        .wr_en         (w_wr_en),
        .wr_piece      (w_wr_piece)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (bus.restart) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= w_wr_inc;
            end
            for (int p = 0; p < 2; p++) begin
                if (w_pop_ok[p]) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + c_one;
                end
            end
        end
    end

    // Storage needs no reset: entries are only visible between pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr[PW-2:0]] <= w_wr_piece;
        end
    end

    assign bus.piece_valid = w_valid;
    assign bus.piece_p0    = w_valid[0] ? r_buf[r_rd_ptr[0][PW-2:0]] : PIECE_NONE;
    assign bus.piece_p1    = w_valid[1] ? r_buf[r_rd_ptr[1][PW-2:0]] : PIECE_NONE;
    assign bus.queue_full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_piece_bag_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piece_bag_sched
//  Description : Scoreboard bench for piece_bag_sched. Each scripted draw
//                is run through a bag model; accepted pieces are queued per
//                player and every cycle the DUT heads/valid/full are
//                compared against the queues.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piece_bag_sched;
    import tetris_pkg::*;

    localparam int QDEPTH = 8;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    always #5 clk = ~clk;

    piece_bag_sched_if bus ();

    piece_bag_sched #(.QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] exp_q [2][$];
    logic [6:0] m_bag;
    bit         m_idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_full();
        return (exp_q[0].size() == QDEPTH) || (exp_q[1].size() == QDEPTH);
    endfunction

    task automatic model_clear();
        exp_q[0].delete();
        exp_q[1].delete();
        m_bag  = 7'h7F;
        m_idle = 1'b1;
    endtask

    task automatic check_outputs();
        logic [2:0] h0;
        logic [2:0] h1;
        h0 = (exp_q[0].size() != 0) ? exp_q[0][0] : 3'd7;
        h1 = (exp_q[1].size() != 0) ? exp_q[1][0] : 3'd7;
        chk("valid0", 32'(bus.piece_valid[0]), 32'(exp_q[0].size() != 0));
        chk("valid1", 32'(bus.piece_valid[1]), 32'(exp_q[1].size() != 0));
        chk("head0",  32'(bus.piece_p0), 32'(h0));
        chk("head1",  32'(bus.piece_p1), 32'(h1));
        chk("full",   32'(bus.queue_full), 32'(model_full()));
    endtask

    // One clock: drive, compare at negedge, retire model pops, step past edge.
    task automatic cycle(input logic rb, input logic [1:0] pm);
        bus.rnd_bit = rb;
        bus.pop     = pm;
        @(negedge clk);
        check_outputs();
        for (int p = 0; p < 2; p++) begin
            if (pm[p] && exp_q[p].size() != 0) begin
                void'(exp_q[p].pop_front());
            end
        end
        @(posedge clk);
        #1;
        bus.pop = 2'b00;
    endtask

    // Bring the generator to the first SHIFT cycle if it is sitting in IDLE.
    task automatic begin_draw();
        if (m_idle) begin
            for (int guard = 0; guard < 4 && model_full(); guard++) begin
                cycle(1'b0, 2'b11);
            end
            cycle(1'b0, 2'b00);
            m_idle = 1'b0;
        end
    endtask

    task automatic draw_body(input logic [2:0] c, input logic [7:0] pops);
        int ci;
        cycle(c[2], pops[1:0]);
        cycle(c[1], pops[3:2]);
        cycle(c[0], pops[5:4]);
        cycle(1'b0, pops[7:6]);
        ci = int'(c);
        if (ci < 7 && m_bag[ci]) begin
            exp_q[0].push_back(c);
            exp_q[1].push_back(c);
            m_bag[ci] = 1'b0;
            if (m_bag == 7'h00) m_bag = 7'h7F;
            if (model_full()) m_idle = 1'b1;
        end
    endtask

    task automatic draw(input logic [2:0] c, input logic [7:0] pops);
        begin_draw();
        draw_body(c, pops);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rnd_bit = 1'b0;
        bus.restart = 1'b0;
        bus.pop     = 2'b00;
        model_clear();

        // Reset state.
        cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b00);
        rst_l = 1'b1;

        // First draw T; reject 7 then S; fill the bag with a duplicate T.
        draw(3'd2, 8'h00);
        draw(3'd7, 8'h00);
        draw(3'd3, 8'h00);
        draw(3'd0, 8'h00);
        draw(3'd1, 8'h00);
        draw(3'd4, 8'h00);
        draw(3'd5, 8'h00);
        draw(3'd2, 8'h00);          // duplicate T, rejected
        draw(3'd6, 8'h00);          // completes the bag, refill
        draw(3'd2, 8'h00);          // T accepted again; 8th piece -> full

        // Full: generator holds, rnd bits ignored, p0 pops do not unblock.
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b00);
        cycle(1'b0, 2'b01);
        cycle(1'b0, 2'b01);
        cycle(1'b0, 2'b01);
        cycle(1'b1, 2'b00);
        cycle(1'b0, 2'b10);         // slowest player pops: draw starts next
        draw(3'd1, 8'h00);
        draw(3'd5, 8'h00);

        // Random draws and pops to wrap pointers many times.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] c;
            logic [7:0] pm;
            c  = 3'($urandom_range(0, 7));
            pm = 8'($urandom) & 8'($urandom | 32'h55);
            draw(c, pm);
        end

        // Restart during the second SHIFT cycle, with pops in that cycle.
        begin_draw();
        cycle(1'b1, 2'b00);
        bus.restart = 1'b1;
        cycle(1'b0, 2'b11);
        bus.restart = 1'b0;
        model_clear();
        draw(3'd2, 8'h00);          // T accepted: bag fresh
        draw(3'd2, 8'h00);          // duplicate rejected
        draw(3'd0, 8'h00);

        // Async reset while in PICK with an acceptable candidate.
        begin_draw();
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b00);
        cycle(1'b0, 2'b00);         // now in PICK with candidate L
        rst_l = 1'b0;
        model_clear();
        cycle(1'b0, 2'b00);
        rst_l = 1'b1;
        draw(3'd6, 8'h00);          // L accepted: bag fresh, nothing leaked
        draw(3'd4, 8'h01);
        draw(3'd4, 8'h03);
        draw(3'd1, 8'h0F);
        begin_draw();
        cycle(1'b0, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piece_bag_sched.md
Name: piece_bag_sched

Overview:
Seven-bag tetromino sequencer for two-player games. It consumes one pseudo-random bit per cycle from the shared 31-bit LFSR and shuffles pieces with rejection sampling. It writes the drawn pieces into one shared sequence buffer. Each player has an independent read pointer, so both players receive the identical piece sequence at their own pace. It sits between the LFSR instance and the two per-player game-logic blocks.

Parameters:
QDEPTH, 8, sequence buffer entries; power of 2, minimum 2.
PW, $clog2(QDEPTH)+1, pointer width including wrap bit (localparam).

Ports:
clk  input  1  clock.
rst_l  input  1  asynchronous, active-low reset.
rnd_bit  input  1  LFSR output bit; sampled only in SHIFT.
restart  input  1  synchronous game restart; aborts draw, clears buffer and bag.
pop  input  2  pop[p]: player p consumes its head piece.
piece_valid  output  2  player p has at least one unread piece.
piece_p0  output  3  player 0 head piece (piece_t).
piece_p1  output  3  player 1 head piece (piece_t).
queue_full  output  1  slowest player's occupancy equals QDEPTH.

Behaviour:
- piece_t encoding: I=0, O=1, T=2, S=3, Z=4, J=5, L=6, NONE=7.
- Reset or restart values:
  - wr_ptr, rd_ptr[0], rd_ptr[1] = 0.
  - bag = 7'h7F (1 = piece still available).
  - cand = 0; FSM = IDLE.
  - piece_valid = 0; piece_pX = NONE; queue_full = 0.
- Occupancy: occ[p] = wr_ptr - rd_ptr[p], computed mod 2^PW. full = max(occ[0], occ[1]) == QDEPTH. full is evaluated from registered pointers at the start of the cycle.
- FSM states:
  - IDLE: if !full, go to SHIFT (cnt=0); otherwise stay.
  - SHIFT: cand <= {cand[1:0], rnd_bit}; cnt++. After the third bit is shifted in, go to PICK. SHIFT always lasts exactly 3 cycles.
  - PICK, reject case: if cand==7 or bag[cand]==0, go to SHIFT (cnt=0). Nothing is written.
  - PICK, accept case:
    - buf[wr_ptr[PW-2:0]] <= cand; wr_ptr++; bag[cand] <= 0.
    - If this clears the last set bag bit, bag <= 7'h7F in the same edge.
    - Next state is SHIFT if the post-write buffer is not full, otherwise IDLE.
    - The post-write full check uses post-pop pointers for that edge.
- Full can only be seen in IDLE; the FSM never writes while full. Write and read slots therefore never alias.
- Latency: from IDLE with a good first draw, the piece is visible after 5 edges (1 IDLE + 3 SHIFT + 1 PICK). Back-to-back accepted draws occur every 4 cycles.
- Per-player outputs:
  - piece_valid[p] = occ[p] != 0.
  - piece_pX = buf[rd_ptr[p]] when valid, else NONE. This is a combinational read of registered state.
- Pop handling:
  - pop[p] with valid: rd_ptr[p]++ at the edge.
  - pop[p] while !valid: ignored; no pointer change.
  - Pops from both players in the same cycle are independent.
  - A pop and a write in the same cycle are both honoured. A pop on an empty queue in the same cycle as a write is ignored; the written piece appears next cycle.
- Fairness invariant: every 7 consecutive accepted pieces starting at index 0 after reset/restart form a permutation of 0..6.
- Restart in any state takes priority over pops and writes. Async reset mid-PICK leaves no write.
- Pointer wrap: pointers wrap mod 2^PW, and occupancy stays correct across the wrap.

Decomposition:
- Package tetris_pkg:
  - piece_t enum (3-bit, values above, including NONE).
  - BAG_FULL = 7'h7F.
  - Generator state enum {IDLE, SHIFT, PICK}.
- Natural sub-module: bag_draw_fsm, containing the FSM, cand, cnt and bag. Its outputs are wr_en and wr_piece; its inputs are rnd_bit, full and restart.
- The buffer and read pointers stay in piece_bag_sched.

Test Plan:
1. Release reset, rnd_bit = 0,1,0 in the SHIFT cycles -> piece_p0 = piece_p1 = T(2), piece_valid = 2'b11 after edge 5; NONE before.
2. rnd_bit = 1,1,1 then 0,1,1 -> first PICK rejects with no write; S(3) appears 4 cycles later than case 1.
3. Script draws 0..6 with a duplicate T attempted before the 7th -> duplicate rejected; after the 7th accept, bag = 7'h7F and a T draw is accepted.
4. No pops for 8 accepts -> queue_full = 1, FSM holds IDLE. Pop p0 x3 -> still full. Single pop p1 -> a draw starts the next cycle.
5. p0 pops 3 times, p1 none -> piece_p0 = 4th written piece, piece_p1 = 1st. Both players observe the identical order over 20 pieces across pointer wrap.
6. Assert restart during SHIFT cnt=1, and separately rst_l low during PICK -> next cycle piece_valid = 0, both outputs NONE, bag = 7'h7F, and no partial piece is ever written.
